// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the rv32i memory path: access sizes, requester owner ids
// and the return-tag layout carried through the arbiter's read-return pipe.
package rv32_mem_pkg;

    localparam logic [1:0] MODE_B = 2'b00;
    localparam logic [1:0] MODE_H = 2'b01;
    localparam logic [1:0] MODE_W = 2'b10;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // One tag per issued cycle: valid marks a read, owner says who gets the data.
    typedef struct packed {
        logic valid;
        logic owner;
    } ret_tag_t;

    // Build the tag pushed into the return pipe for the current cycle.
    function automatic ret_tag_t make_tag(input logic is_read, input logic owner);
        ret_tag_t t;
        t.valid = is_read;
        t.owner = is_read ? owner : OWN_I;
        return t;
    endfunction

endpackage

// File: rtl/arb_ret_pipe.sv
// Fixed-depth tag shift register: one entry per cycle, tail emerges DEPTH
// cycles after the push, matching the memory's read latency.
module arb_ret_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [W-1:0] tag_i,
    output logic [W-1:0] tag_o
);

    logic [W-1:0] pipe_q [DEPTH];

    // Shift tags toward the tail each cycle; reset discards everything in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data wins by default; a saturating starvation counter forces a fetch grant
// after STARVE_MAX consecutive fetch losses. Read returns are routed by a tag
// pipe that mirrors the memory's fixed read latency.
module mem_arb
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STORE_M    = 2,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_gnt,
    output logic               i_rvalid,
    output logic [DATA_W-1:0]  i_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [STORE_M-1:0] d_mode,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               m_en,
    output logic               m_we,
    output logic [STORE_M-1:0] m_mode,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [DATA_W-1:0]  m_wdata,
    input  logic [DATA_W-1:0]  m_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]         starve_q;
    logic [3:0]         starve_d;
    logic               starve_full_s;
    logic               i_gnt_s;
    logic               d_gnt_s;
    logic               m_en_s;
    logic               m_we_s;
    logic [STORE_M-1:0] m_mode_s;
    logic [ADDR_W-1:0]  m_addr_s;
    logic [DATA_W-1:0]  m_wdata_s;
    ret_tag_t           tag_in_s;
    ret_tag_t           tag_out_s;

    assign starve_full_s = (starve_q == STARVE_LIM);

    // Grant selection: data by default, fetch when alone or when starved.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!n_rst) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (d_req && !(i_req && starve_full_s)) begin
            d_gnt_s = 1'b1;
        end else if (i_req) begin
            i_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Next starvation count: count fetch losses, clear on fetch win or no fetch.
    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_gnt_s) begin
            starve_d = 4'd0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Drive the memory command from whichever request was granted.
    always_comb begin
        m_en_s    = 1'b0;
        m_we_s    = 1'b0;
        m_mode_s  = '0;
        m_addr_s  = '0;
        m_wdata_s = '0;
        case ({i_gnt_s, d_gnt_s})
            2'b10: begin
                m_en_s   = 1'b1;
                m_we_s   = 1'b0;
                m_mode_s = STORE_M'(MODE_W);
                m_addr_s = i_addr;
            end
            2'b01: begin
                m_en_s    = 1'b1;
                m_we_s    = d_we;
                m_mode_s  = d_mode;
                m_addr_s  = d_addr;
                m_wdata_s = d_wdata;
            end
            default: begin
                m_en_s    = 1'b0;
                m_we_s    = 1'b0;
                m_mode_s  = '0;
                m_addr_s  = '0;
                m_wdata_s = '0;
            end
        endcase
    end

    assign tag_in_s = make_tag(m_en_s & ~m_we_s, d_gnt_s ? OWN_D : OWN_I);

    arb_ret_pipe #(
        .DEPTH (RD_LAT),
        .W     (2)
    ) u_ret_pipe (
        .clk   (clk),
        .n_rst (n_rst),
        .tag_i (tag_in_s),
        .tag_o (tag_out_s)
    );

    assign i_gnt    = i_gnt_s;
    assign d_gnt    = d_gnt_s;
    assign m_en     = m_en_s;
    assign m_we     = m_we_s;
    assign m_mode   = m_mode_s;
    assign m_addr   = m_addr_s;
    assign m_wdata  = m_wdata_s;
    assign i_rvalid = tag_out_s.valid & (tag_out_s.owner == OWN_I);
    assign d_rvalid = tag_out_s.valid & (tag_out_s.owner == OWN_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: two instances share stimulus, one with RD_LAT=1
// and one with RD_LAT=3, both with STARVE_MAX=3.
module tb_mem_arb;

    logic        clk;
    logic        n_rst;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_mode;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] m_rdata;

    logic        a1_i_gnt, a1_i_rvalid, a1_d_gnt, a1_d_rvalid, a1_m_en, a1_m_we;
    logic [31:0] a1_i_rdata, a1_d_rdata, a1_m_wdata;
    logic [1:0]  a1_m_mode;
    logic [7:0]  a1_m_addr;
    logic        a3_i_gnt, a3_i_rvalid, a3_d_gnt, a3_d_rvalid, a3_m_en, a3_m_we;
    logic [31:0] a3_i_rdata, a3_d_rdata, a3_m_wdata;
    logic [1:0]  a3_m_mode;
    logic [7:0]  a3_m_addr;

    int tests_run;
    int fails;

    mem_arb #(.ADDR_W(8), .DATA_W(32), .STORE_M(2), .RD_LAT(1), .STARVE_MAX(3)) u_a1 (
        .clk(clk), .n_rst(n_rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a1_i_gnt), .i_rvalid(a1_i_rvalid), .i_rdata(a1_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a1_d_gnt), .d_rvalid(a1_d_rvalid), .d_rdata(a1_d_rdata),
        .m_en(a1_m_en), .m_we(a1_m_we), .m_mode(a1_m_mode), .m_addr(a1_m_addr),
        .m_wdata(a1_m_wdata), .m_rdata(m_rdata)
    );

    mem_arb #(.ADDR_W(8), .DATA_W(32), .STORE_M(2), .RD_LAT(3), .STARVE_MAX(3)) u_a3 (
        .clk(clk), .n_rst(n_rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a3_i_gnt), .i_rvalid(a3_i_rvalid), .i_rdata(a3_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a3_d_gnt), .d_rvalid(a3_d_rvalid), .d_rdata(a3_d_rdata),
        .m_en(a3_m_en), .m_we(a3_m_we), .m_mode(a3_m_mode), .m_addr(a3_m_addr),
        .m_wdata(a3_m_wdata), .m_rdata(m_rdata)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        m_rdata = 32'h0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        n_rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 8'h33; d_addr = 8'h55; d_mode = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            tests_run++;
            if ({a1_i_gnt, a1_d_gnt, a1_i_rvalid, a1_d_rvalid, a1_m_en, a1_m_we,
                 a3_i_gnt, a3_d_gnt, a3_i_rvalid, a3_d_rvalid, a3_m_en, a3_m_we} !== 12'h000
                || a1_m_addr !== 8'h00 || a1_m_mode !== 2'b00) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: a1 gi=%b gd=%b en=%b addr=%h mode=%b a3 gi=%b gd=%b en=%b, want all 0",
                         k, a1_i_gnt, a1_d_gnt, a1_m_en, a1_m_addr, a1_m_mode, a3_i_gnt, a3_d_gnt, a3_m_en);
            end
        end
        step();
        n_rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({a1_i_gnt, a1_d_gnt, a3_i_gnt, a3_d_gnt} !== 4'b0101 || a1_m_addr !== 8'h55) begin
            fails++;
            $display("FAIL reset_first_grant: a1 i/d=%b%b a3 i/d=%b%b addr=%h, want 01 01 addr=55",
                     a1_i_gnt, a1_d_gnt, a3_i_gnt, a3_d_gnt, a1_m_addr);
        end
        idle(5);
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 8'h10;
        @(negedge clk);
        tests_run++;
        if ({a1_i_gnt, a1_d_gnt, a1_m_en, a1_m_we} !== 4'b1010 || a1_m_addr !== 8'h10 || a1_m_mode !== 2'b10) begin
            fails++;
            $display("FAIL fetch_cmd: gi=%b gd=%b en=%b we=%b addr=%h mode=%b, want 1 0 1 0 10 10",
                     a1_i_gnt, a1_d_gnt, a1_m_en, a1_m_we, a1_m_addr, a1_m_mode);
        end
        step();
        i_req = 1'b0; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        tests_run++;
        if ({a1_i_rvalid, a1_d_rvalid, a1_m_en} !== 3'b100 || a1_i_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL fetch_return: irv=%b drv=%b en=%b data=%h, want 1 0 0 deadbeef",
                     a1_i_rvalid, a1_d_rvalid, a1_m_en, a1_i_rdata);
        end
        idle(5);
    endtask

    task automatic test_starve();
        logic [7:0] exp_i;
        exp_i = 8'b1000_1000;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; i_addr = 8'h04; d_addr = 8'h80; d_mode = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests_run++;
            if ({a1_i_gnt, a1_d_gnt, a3_i_gnt, a3_d_gnt} !== {exp_i[k], ~exp_i[k], exp_i[k], ~exp_i[k]}) begin
                fails++;
                $display("FAIL starve_seq cyc%0d: a1 i/d=%b%b a3 i/d=%b%b, want i=%b", k,
                         a1_i_gnt, a1_d_gnt, a3_i_gnt, a3_d_gnt, exp_i[k]);
            end
            step();
        end
        idle(5);
    endtask

    task automatic test_starve_drop();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 8'h90;
        step(); step(); step();
        i_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a1_i_gnt, a1_d_gnt} !== 2'b01) begin
            fails++;
            $display("FAIL starve_drop_d: i/d=%b%b, want 01", a1_i_gnt, a1_d_gnt);
        end
        step();
        i_req = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({a1_i_gnt, a1_d_gnt} !== 2'b01) begin
            fails++;
            $display("FAIL starve_drop_clear: i/d=%b%b, want 01 (counter cleared)", a1_i_gnt, a1_d_gnt);
        end
        idle(5);
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_mode = 2'b10; d_wdata = 32'h12345678;
        @(negedge clk);
        tests_run++;
        if ({a1_d_gnt, a1_i_gnt, a1_m_en, a1_m_we} !== 4'b1011 || a1_m_wdata !== 32'h12345678
            || a1_m_addr !== 8'h20 || a1_m_mode !== 2'b10) begin
            fails++;
            $display("FAIL store_cmd: gd=%b gi=%b en=%b we=%b wdata=%h addr=%h mode=%b, want 1 0 1 1 12345678 20 10",
                     a1_d_gnt, a1_i_gnt, a1_m_en, a1_m_we, a1_m_wdata, a1_m_addr, a1_m_mode);
        end
        step();
        d_req = 1'b0; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if ({a1_i_rvalid, a1_d_rvalid, a3_i_rvalid, a3_d_rvalid, a1_m_wdata} !== 36'h0) begin
                fails++;
                $display("FAIL store_no_rvalid cyc%0d: a1 %b%b a3 %b%b wdata=%h, want 0", k + 1,
                         a1_i_rvalid, a1_d_rvalid, a3_i_rvalid, a3_d_rvalid, a1_m_wdata);
            end
            step();
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_i;
        logic [2:0]  exp_d;
        logic [31:0] rd [3];
        exp_i = 3'b101; exp_d = 3'b010;
        rd[0] = 32'hA0000001; rd[1] = 32'hB0000002; rd[2] = 32'hC0000003;
        i_req = 1'b1; i_addr = 8'h00;
        @(negedge clk);
        tests_run++;
        if ({a3_i_gnt, a3_d_gnt} !== 2'b10 || a3_m_addr !== 8'h00) begin
            fails++;
            $display("FAIL b2b_issue0: i/d=%b%b addr=%h, want 10 00", a3_i_gnt, a3_d_gnt, a3_m_addr);
        end
        step();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40; d_mode = 2'b10;
        @(negedge clk);
        tests_run++;
        if ({a3_i_gnt, a3_d_gnt, a3_m_we} !== 3'b010 || a3_m_addr !== 8'h40) begin
            fails++;
            $display("FAIL b2b_issue1: i/d/we=%b%b%b addr=%h, want 010 40", a3_i_gnt, a3_d_gnt, a3_m_we, a3_m_addr);
        end
        step();
        d_req = 1'b0; i_req = 1'b1; i_addr = 8'h04;
        @(negedge clk);
        tests_run++;
        if ({a3_i_gnt, a3_d_gnt, a3_i_rvalid, a3_d_rvalid} !== 4'b1000 || a3_m_addr !== 8'h04) begin
            fails++;
            $display("FAIL b2b_issue2: i/d=%b%b rv=%b%b addr=%h, want 10 00 04",
                     a3_i_gnt, a3_d_gnt, a3_i_rvalid, a3_d_rvalid, a3_m_addr);
        end
        step();
        i_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_rdata = rd[k];
            @(negedge clk);
            tests_run++;
            if ({a3_i_rvalid, a3_d_rvalid} !== {exp_i[k], exp_d[k]}
                || (exp_i[k] && a3_i_rdata !== rd[k]) || (exp_d[k] && a3_d_rdata !== rd[k])) begin
                fails++;
                $display("FAIL b2b_return cyc%0d: irv=%b drv=%b idata=%h ddata=%h, want %b %b data=%h",
                         k + 3, a3_i_rvalid, a3_d_rvalid, a3_i_rdata, a3_d_rdata, exp_i[k], exp_d[k], rd[k]);
            end
            step();
        end
        m_rdata = 32'h0;
        @(negedge clk);
        tests_run++;
        if ({a3_i_rvalid, a3_d_rvalid} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_drained: rv=%b%b, want 00", a3_i_rvalid, a3_d_rvalid);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        i_req = 1'b1; i_addr = 8'h08;
        @(negedge clk);
        tests_run++;
        if ({a3_i_gnt, a3_d_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL rstmid_issue0: i/d=%b%b, want 10", a3_i_gnt, a3_d_gnt);
        end
        step();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h44;
        @(negedge clk);
        tests_run++;
        if ({a3_i_gnt, a3_d_gnt} !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_issue1: i/d=%b%b, want 01", a3_i_gnt, a3_d_gnt);
        end
        step();
        d_req = 1'b0; n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests_run++;
            if ({a1_i_rvalid, a1_d_rvalid, a3_i_rvalid, a3_d_rvalid} !== 4'b0000) begin
                fails++;
                $display("FAIL rstmid_no_rvalid cyc%0d: a1 %b%b a3 %b%b, want 0000", k,
                         a1_i_rvalid, a1_d_rvalid, a3_i_rvalid, a3_d_rvalid);
            end
            step();
        end
    endtask

    // Test sequence.
    initial begin
        tests_run = 0; fails = 0;
        n_rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 8'h00; d_addr = 8'h00; d_mode = 2'b00; d_wdata = 32'h0; m_rdata = 32'h0;
        test_reset();
        test_fetch();
        test_starve();
        test_starve_drop();
        test_store();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
